// File: rtl/thumb_decode_stage.sv
// thumb_decode_stage: registered, flow-controlled Thumb halfword decoder.
//   Accepts halfword + PC from fetch (i_valid/o_ready) and presents a decoded
//   bundle (o_valid/i_out_ready) one cycle later. A one-entry skid buffer
//   (SKID_EN=1) keeps o_ready independent of the downstream ready. BL is
//   assembled from its two halfwords by a small prefix state machine.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_flush             synchronous flush of the stage
//   i_valid/o_ready     input handshake; i_ir halfword, i_pc its address
//   o_valid/i_out_ready output handshake
//   o_op, o_rd, o_rn, o_rt, o_cond, o_imm, o_pc  decoded bundle
module thumb_decode_stage #(
  parameter int unsigned IMM_W   = 32,
  parameter int unsigned SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_ir,
  input  logic [31:0]      i_pc,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [3:0]       o_op,
  output logic [3:0]       o_rd,
  output logic [3:0]       o_rn,
  output logic [3:0]       o_rt,
  output logic [3:0]       o_cond,
  output logic [IMM_W-1:0] o_imm,
  output logic [31:0]      o_pc
);

  localparam int unsigned REG_W = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned HI_W  = 11;
  localparam int unsigned BR_W  = 23;
  localparam bit          SKID  = (SKID_EN != 0);

  localparam logic [REG_W-1:0] OP_ADD_I   = 4'd1;
  localparam logic [REG_W-1:0] OP_SUB_SP  = 4'd2;
  localparam logic [REG_W-1:0] OP_MOV_I   = 4'd3;
  localparam logic [REG_W-1:0] OP_MOV_R   = 4'd4;
  localparam logic [REG_W-1:0] OP_LDR     = 4'd5;
  localparam logic [REG_W-1:0] OP_STR     = 4'd6;
  localparam logic [REG_W-1:0] OP_B_COND  = 4'd7;
  localparam logic [REG_W-1:0] OP_CMP_I   = 4'd8;
  localparam logic [REG_W-1:0] OP_B       = 4'd9;
  localparam logic [REG_W-1:0] OP_BL      = 4'd10;
  localparam logic [REG_W-1:0] OP_ILLEGAL = 4'd15;
  localparam logic [REG_W-1:0] COND_AL    = 4'hE;
  localparam logic [REG_W-1:0] REG_SP     = 4'd13;
  localparam logic [REG_W-1:0] REG_LR     = 4'd14;
  localparam logic [REG_W-1:0] REG_PC     = 4'd15;

  typedef struct packed {
    logic [REG_W-1:0] op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] cond;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  pc;
  } bundle_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_PREFIX = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [HI_W-1:0]    hi_q, hi_d;
  logic [PC_W-1:0]    ppc_q, ppc_d;
  bundle_t            out_q, skid_q, dec_c;
  logic               valid_q, skid_full_q;
  logic               emit_c, accept_c, push_c, out_free_c;

  // Branch offsets are first formed as 23-bit signed values, then widened.
  function automatic logic [IMM_W-1:0] sext_br(input logic [BR_W-1:0] v);
    return {{(IMM_W-BR_W){v[BR_W-1]}}, v};
  endfunction

  assign out_free_c = !valid_q || i_out_ready;
  assign o_ready    = SKID ? !skid_full_q : out_free_c;
  assign accept_c   = i_valid && o_ready;
  assign push_c     = accept_c && emit_c;

  // Halfword decode including the BL prefix/suffix pairing.
  always_comb begin
    dec_c      = '0;
    dec_c.op   = OP_ILLEGAL;
    dec_c.cond = COND_AL;
    dec_c.pc   = i_pc;
    emit_c     = 1'b1;
    state_d    = ST_IDLE;
    hi_d       = hi_q;
    ppc_d      = ppc_q;
    if (state_q == ST_PREFIX) begin
      // Second halfword is always consumed; anything but a suffix is ILLEGAL.
      dec_c.pc = ppc_q;
      if (i_ir[15:11] == 5'b11111) begin
        dec_c.op  = OP_BL;
        dec_c.rd  = REG_LR;
        dec_c.rn  = REG_PC;
        dec_c.imm = sext_br({hi_q, i_ir[10:0], 1'b0});
      end
    end else if (i_ir[15:11] == 5'b11110) begin
      emit_c  = 1'b0;
      state_d = ST_PREFIX;
      hi_d    = i_ir[10:0];
      ppc_d   = i_pc;
    end else if (i_ir[15:9] == 7'b0001110) begin
      dec_c.op  = OP_ADD_I;
      dec_c.rd  = REG_W'(i_ir[2:0]);
      dec_c.rn  = REG_W'(i_ir[5:3]);
      dec_c.imm = IMM_W'(i_ir[8:6]);
    end else if (i_ir[15:7] == 9'b101100001) begin
      dec_c.op  = OP_SUB_SP;
      dec_c.rd  = REG_SP;
      dec_c.rn  = REG_SP;
      dec_c.imm = IMM_W'({i_ir[6:0], 2'b00});
    end else if (i_ir[15:11] == 5'b00100) begin
      dec_c.op  = OP_MOV_I;
      dec_c.rd  = REG_W'(i_ir[10:8]);
      dec_c.imm = IMM_W'(i_ir[7:0]);
    end else if (i_ir[15:8] == 8'b01000110) begin
      dec_c.op = OP_MOV_R;
      dec_c.rd = {i_ir[7], i_ir[2:0]};
      dec_c.rn = i_ir[6:3];
    end else if (i_ir[15:12] == 4'b0110) begin
      // LDR (bit 11 set) and STR share the field layout.
      dec_c.op  = i_ir[11] ? OP_LDR : OP_STR;
      dec_c.rt  = REG_W'(i_ir[2:0]);
      dec_c.rn  = REG_W'(i_ir[5:3]);
      dec_c.imm = IMM_W'({i_ir[10:6], 2'b00});
    end else if (i_ir[15:12] == 4'b1101 && i_ir[11:9] != 3'b111) begin
      dec_c.op   = OP_B_COND;
      dec_c.cond = i_ir[11:8];
      dec_c.rn   = REG_PC;
      dec_c.imm  = sext_br({{14{i_ir[7]}}, i_ir[7:0], 1'b0});
    end else if (i_ir[15:11] == 5'b00101) begin
      dec_c.op  = OP_CMP_I;
      dec_c.rn  = REG_W'(i_ir[10:8]);
      dec_c.imm = IMM_W'(i_ir[7:0]);
    end else if (i_ir[15:11] == 5'b11100) begin
      dec_c.op  = OP_B;
      dec_c.rn  = REG_PC;
      dec_c.imm = sext_br({{11{i_ir[10]}}, i_ir[10:0], 1'b0});
    end
  end

  // Prefix FSM, output register and skid entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      ppc_q       <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else if (i_flush) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      if (accept_c) begin
        state_q <= state_d;
        hi_q    <= hi_d;
        ppc_q   <= ppc_d;
      end
      if (out_free_c) begin
        if (SKID && skid_full_q) begin
          // Oldest bundle leaves the skid entry first to keep order.
          out_q       <= skid_q;
          valid_q     <= 1'b1;
          skid_full_q <= push_c;
          if (push_c) begin
            skid_q <= dec_c;
          end
        end else if (push_c) begin
          out_q   <= dec_c;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end else if (SKID && push_c) begin
        skid_q      <= dec_c;
        skid_full_q <= 1'b1;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_op    = out_q.op;
  assign o_rd    = out_q.rd;
  assign o_rn    = out_q.rn;
  assign o_rt    = out_q.rt;
  assign o_cond  = out_q.cond;
  assign o_imm   = out_q.imm;
  assign o_pc    = out_q.pc;

endmodule

// File: tb/tb_thumb_decode_stage.sv
// Testbench for thumb_decode_stage: directed scenarios plus randomized traffic
// against an arithmetic reference decoder; expected bundles are queued at
// acceptance and checked by an independent output monitor.
module tb_thumb_decode_stage;

  localparam int unsigned IMM_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [15:0]      i_ir = '0;
  logic [31:0]      i_pc = '0;
  logic             o_valid;
  logic             i_out_ready = 1'b1;
  logic [3:0]       o_op, o_rd, o_rn, o_rt, o_cond;
  logic [IMM_W-1:0] o_imm;
  logic [31:0]      o_pc;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rt;
    logic [3:0]  cond;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_pend  = 1'b0;
  int          m_hi    = 0;
  logic [31:0] m_ppc   = '0;
  bit          held_prev = 1'b0;
  exp_t        snap;

  thumb_decode_stage #(.IMM_W(IMM_W), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_ir(i_ir), .i_pc(i_pc), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_op(o_op), .o_rd(o_rd), .o_rn(o_rn), .o_rt(o_rt), .o_cond(o_cond),
    .o_imm(o_imm), .o_pc(o_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic exp_t cur_out();
    exp_t c;
    c.op = o_op; c.rd = o_rd; c.rn = o_rn; c.rt = o_rt; c.cond = o_cond;
    c.imm = o_imm; c.pc = o_pc;
    return c;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_bundle(input string name, input exp_t got, input exp_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got op=%0d rd=%0d rn=%0d rt=%0d cond=%h imm=%h pc=%h want op=%0d rd=%0d rn=%0d rt=%0d cond=%h imm=%h pc=%h",
               name, got.op, got.rd, got.rn, got.rt, got.cond, got.imm, got.pc,
               want.op, want.rd, want.rn, want.rt, want.cond, want.imm, want.pc);
    end
  endtask

  // Reference decoder: field extraction and signed arithmetic on integers.
  task automatic model_step(input logic [15:0] hw, input logic [31:0] pc,
                            output bit emit, output exp_t e);
    int s;
    int top5;
    top5 = int'(hw[15:11]);
    e = '0;
    e.op = 4'd15; e.cond = 4'hE; e.pc = pc;
    emit = 1'b1;
    if (m_pend) begin
      m_pend = 1'b0;
      e.pc = m_ppc;
      if (top5 == 31) begin
        s = m_hi * 2048 + int'(hw[10:0]);
        if (m_hi >= 1024) s = s - (1 << 22);
        e.op = 4'd10; e.rd = 4'd14; e.rn = 4'd15; e.imm = 32'(s * 2);
      end
    end else if (top5 == 30) begin
      emit = 1'b0; m_pend = 1'b1; m_hi = int'(hw[10:0]); m_ppc = pc;
    end else if (int'(hw[15:9]) == 14) begin
      e.op = 4'd1; e.rd = 4'(hw[2:0]); e.rn = 4'(hw[5:3]); e.imm = 32'(hw[8:6]);
    end else if (int'(hw[15:7]) == 'h161) begin
      e.op = 4'd2; e.rd = 4'd13; e.rn = 4'd13; e.imm = 32'(int'(hw[6:0]) * 4);
    end else if (top5 == 4) begin
      e.op = 4'd3; e.rd = 4'(hw[10:8]); e.imm = 32'(hw[7:0]);
    end else if (int'(hw[15:8]) == 'h46) begin
      e.op = 4'd4; e.rd = 4'(int'(hw[7]) * 8 + int'(hw[2:0])); e.rn = hw[6:3];
    end else if (top5 == 13 || top5 == 12) begin
      e.op = (top5 == 13) ? 4'd5 : 4'd6;
      e.rt = 4'(hw[2:0]); e.rn = 4'(hw[5:3]); e.imm = 32'(int'(hw[10:6]) * 4);
    end else if (int'(hw[15:12]) == 13 && int'(hw[11:8]) < 14) begin
      s = int'(hw[7:0]);
      if (s >= 128) s = s - 256;
      e.op = 4'd7; e.cond = hw[11:8]; e.rn = 4'd15; e.imm = 32'(s * 2);
    end else if (top5 == 5) begin
      e.op = 4'd8; e.rn = 4'(hw[10:8]); e.imm = 32'(hw[7:0]);
    end else if (top5 == 28) begin
      s = int'(hw[10:0]);
      if (s >= 1024) s = s - 2048;
      e.op = 4'd9; e.rn = 4'd15; e.imm = 32'(s * 2);
    end
  endtask

  // One clock: record acceptance before the edge, apply flush after it.
  task automatic tick(output bit acc);
    bit   fl;
    bit   emit;
    exp_t e;
    @(negedge clk);
    acc = rst && i_valid && o_ready;
    fl  = i_flush;
    if (acc && !fl) begin
      model_step(i_ir, i_pc, emit, e);
      if (emit) exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      m_pend = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) tick(acc);
  endtask

  task automatic send(input logic [15:0] hw, input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    i_valid = 1'b1; i_ir = hw; i_pc = pc;
    for (int k = 0; k < 40 && !acc; k++) tick(acc);
    check_val("send_accepted", 32'(acc), 32'd1);
    i_valid = 1'b0;
  endtask

  function automatic logic [15:0] gen_hw();
    logic [15:0] r;
    r = 16'($urandom());
    case ($urandom_range(0, 11))
      0:       return {7'b0001110, r[8:0]};
      1:       return {9'b101100001, r[6:0]};
      2:       return {5'b00100, r[10:0]};
      3:       return {8'b01000110, r[7:0]};
      4:       return {5'b01101, r[10:0]};
      5:       return {5'b01100, r[10:0]};
      6:       return {4'b1101, r[11:0]};
      7:       return {5'b00101, r[10:0]};
      8:       return {5'b11100, r[10:0]};
      9:       return {5'b11110, r[10:0]};
      10:      return {5'b11111, r[10:0]};
      default: return r;
    endcase
  endfunction

  // Output monitor: pops on every output transfer, checks held stability.
  always @(negedge clk) begin
    if (!rst) begin
      held_prev = 1'b0;
    end else begin
      if (held_prev) begin
        check_val("held_valid", 32'(o_valid), 32'd1);
        check_bundle("held_stable", cur_out(), snap);
      end
      if (o_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got op=%0d pc=%h want none", o_op, o_pc);
        end else begin
          check_bundle("bundle", cur_out(), exp_q.pop_front());
        end
      end
      held_prev = o_valid && !i_out_ready && !i_flush;
      snap      = cur_out();
    end
  end

  initial begin
    bit acc;
    #12;
    check_val("reset_valid", 32'(o_valid), 32'd0);
    check_val("reset_ready", 32'(o_ready), 32'd1);
    check_val("reset_fields", 32'({o_op, o_rd, o_rn, o_rt, o_cond}), 32'd0);
    check_val("reset_imm", o_imm, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single ADD_I: one-cycle latency.
    send(16'h1C8A, 32'h40);
    check_val("latency_valid", 32'(o_valid), 32'd1);
    idle(2);

    // Branches, BL pairs, broken prefix, lone suffix.
    send(16'hD0FE, 32'h100); send(16'hE400, 32'h104);
    send(16'hF000, 32'h200); send(16'hF802, 32'h202);
    send(16'hF7FF, 32'h300); send(16'hFFFE, 32'h302);
    send(16'hF000, 32'h400); send(16'h2005, 32'h402);
    send(16'hF802, 32'h404);
    idle(3);

    // Back-pressure: output + skid fill, third input waits.
    i_out_ready = 1'b0;
    send(16'h2001, 32'h500); send(16'h2102, 32'h502);
    check_val("bp_ready_low", 32'(o_ready), 32'd0);
    check_val("bp_valid", 32'(o_valid), 32'd1);
    i_valid = 1'b1; i_ir = 16'h2203; i_pc = 32'h504;
    tick(acc); check_val("bp_third_waits", 32'(acc), 32'd0);
    tick(acc); check_val("bp_third_waits2", 32'(acc), 32'd0);
    i_out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) tick(acc);
    check_val("bp_third_accepted", 32'(acc), 32'd1);
    i_valid = 1'b0;
    idle(4);

    // Flush with output and skid full and an LDR presented.
    i_out_ready = 1'b0;
    send(16'h2011, 32'h600); send(16'h2112, 32'h602);
    i_valid = 1'b1; i_ir = 16'h6848; i_pc = 32'h604; i_flush = 1'b1;
    tick(acc);
    i_flush = 1'b0; i_valid = 1'b0;
    check_val("flush_valid", 32'(o_valid), 32'd0);
    check_val("flush_ready", 32'(o_ready), 32'd1);
    i_out_ready = 1'b1;
    idle(4);

    // Flush while in PREFIX: following suffix is ILLEGAL.
    send(16'hF000, 32'h700);
    i_flush = 1'b1; tick(acc); i_flush = 1'b0;
    send(16'hF802, 32'h702);
    idle(3);

    // Asynchronous reset mid-stream.
    i_out_ready = 1'b0;
    send(16'h2021, 32'h800); send(16'h2122, 32'h802);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_val("arst_valid", 32'(o_valid), 32'd0);
    check_val("arst_ready", 32'(o_ready), 32'd1);
    check_val("arst_fields", 32'({o_op, o_rd, o_rn, o_rt, o_cond}), 32'd0);
    check_val("arst_pc", o_pc, 32'd0);
    exp_q.delete(); m_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; i_out_ready = 1'b1;
    send(16'h1C8A, 32'h900);
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      i_valid     = ($urandom_range(0, 9) < 7);
      i_ir        = gen_hw();
      i_pc        = 32'($urandom()) & 32'hFFFF_FFFE;
      i_out_ready = ($urandom_range(0, 9) < 6);
      i_flush     = ($urandom_range(0, 49) == 0);
      tick(acc);
    end
    i_valid = 1'b0; i_flush = 1'b0; i_out_ready = 1'b1;
    idle(6);
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thumb_decode_stage.md
Name: thumb_decode_stage

Overview:
- Registered, flow-controlled Thumb instruction decode stage. It generalises the existing single-cycle decoder.
- Adds the following:
  - valid/ready handshakes on both sides
  - a skid buffer, so fetch is never back-pressured combinationally
  - two-halfword BL assembly through a prefix state machine
  - a flush input
  - immediate scaling and sign-extension to a parametrised width
- Sits between fetch (halfword + PC) and the register-read/execute stage.

Parameters:
- IMM_W, 32, width of o_imm; legal range 24..32. Sign/zero extension is applied to this width.
- SKID_EN, 1, 1 = 1-entry skid buffer (full throughput under back-pressure); 0 = no skid (i_ready = !o_valid | i_out_ready).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous flush of the whole stage
- i_valid  in  1  input halfword valid
- o_ready  out  1  stage can accept a halfword
- i_ir  in  16  instruction halfword
- i_pc  in  32  address of i_ir
- o_valid  out  1  decoded bundle valid
- i_out_ready  in  1  downstream accepts bundle
- o_op  out  4  op class: ADD_I=1, SUB_SP=2, MOV_I=3, MOV_R=4, LDR=5, STR=6, B_COND=7, CMP_I=8, B=9, BL=10, ILLEGAL=15
- o_rd  out  4  destination register
- o_rn  out  4  first source register
- o_rt  out  4  store/load data register
- o_cond  out  4  branch condition; 4'hE for unconditional
- o_imm  out  IMM_W  final immediate
- o_pc  out  32  PC of the first halfword of the instruction

Behaviour:
- Reset (rst=0, asynchronous) sets all outputs to 0, clears the skid entry and returns the FSM to IDLE. o_ready is 1 after reset.
- A transfer occurs on a clock edge where the valid and ready signals of that interface are both 1. o_ready depends only on registered state.
- Latency: 1 cycle from input acceptance to o_valid when the output register is free or being drained.
- Back-pressure (SKID_EN=1):
  - If the output register is occupied and not drained, an accepted bundle goes into the skid entry.
  - o_ready = !skid_full.
  - When the output drains, the skid entry moves to the output register in the same edge.
  - Order is strictly preserved.
- Held bundle stability: while o_valid=1 and i_out_ready=0, every output is held stable.
- Unused register fields are driven to 0. o_cond=4'hE except for B_COND.
- Decode of i_ir (registers 4-bit, imm zero-extended unless stated):
  - ADD_I, 0001110: rd=[2:0], rn=[5:3], imm=[8:6]
  - SUB_SP, 101100001: rd=rn=13, imm=[6:0]<<2
  - MOV_I, 00100: rd=[10:8], imm=[7:0]
  - MOV_R, 01000110: rd={[7],[2:0]}, rn=[6:3]
  - LDR, 01101: rt=[2:0], rn=[5:3], imm=[10:6]<<2
  - STR, 01100: same fields as LDR
  - B_COND, 1101 with cond [11:8] not 111x: cond=[11:8], rn=15, imm=sext({[7:0],0})
  - CMP_I, 00101: rn=[10:8], imm=[7:0]
  - B, 11100: rn=15, imm=sext({[10:0],0})
  - Everything else is ILLEGAL with imm=0.
- BL FSM:
  - IDLE, halfword 11110:
    - store hi=[10:0] and i_pc
    - no output is produced
    - go to PREFIX
  - PREFIX, halfword 11111: emit BL with rd=14, rn=15, imm=sext({hi,lo,0}) (23 bits, sign bit = hi[10]), o_pc = stored PC; return to IDLE.
  - PREFIX, any other halfword: emit a single ILLEGAL (o_pc = stored PC); the second halfword is consumed and not decoded; return to IDLE.
  - IDLE, halfword 11111: emit ILLEGAL.
- Flush (i_flush=1):
  - next edge clears o_valid and the skid entry and forces IDLE
  - a halfword presented in the same cycle is accepted and dropped
  - flush has priority over every other event

Test Plan:
- Reset then single stream: rst low mid-stream -> all outputs 0 immediately. Release, send 0x1C8A (ADD_I) -> next cycle o_valid=1, op=1, rd=2, rn=1, imm=2.
- Branches: B_COND 0xD0FE at pc 0x100 -> op=7, cond=0, imm=0xFFFFFFFC. B 0xE400 -> op=9, imm=0xFFFFF800.
- BL pair: 0xF000 @0x200 then 0xF802 -> one bundle, op=10, rd=14, imm=4, o_pc=0x200. BL pair 0xF7FF / 0xFFFE -> imm=0xFFFFFFFC.
- Broken prefix: 0xF000 then 0x2005 -> single ILLEGAL with o_pc of the prefix; the MOV is not emitted. Lone 0xF802 -> ILLEGAL.
- Back-pressure (SKID_EN=1): i_out_ready=0 during 3 consecutive valid inputs.
  - 1st input lands in the output register, 2nd in the skid entry.
  - o_ready drops to 0; the 3rd input waits.
  - Release i_out_ready -> all 3 bundles emitted in order with no loss, outputs held stable while stalled.
- Flush: stall with output+skid full, assert i_flush with a valid LDR 0x6848 on input -> next cycle o_valid=0, o_ready=1, the LDR is not emitted. Flush in PREFIX -> following 0xF802 yields ILLEGAL.
